// File: rtl/key_conditioner_if.sv
// Button bundle between the raw key inputs and the conditioned pulse/level outputs.
// master drives raw buttons and observes outputs; slave is the conditioner.
interface key_conditioner_if;
    logic [4:0] key_raw;
    logic [4:0] key_pulse;
    logic [4:0] key_level;

    modport master (output key_raw, input key_pulse, input key_level);
    modport slave  (input key_raw, output key_pulse, output key_level);
endinterface

// File: rtl/key_conditioner.sv
// Five-button conditioner: two-flop synchroniser, debounce, one pulse per press,
// and auto-repeat on up (bit 2) and down (bit 3) while held.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_RATE     = 10000000
) (
    input  logic               CP,
    input  logic               _CR,
    key_conditioner_if.slave   keys
);

    localparam int unsigned CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RR_LAST = TW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} rep_state_t;

    logic [4:0] pulse_v;
    logic [4:0] level_v;

    for (genvar i = 0; i < 5; i++) begin : g_key
        logic          s1, s2, stable, pulse;
        logic [CW-1:0] cnt;
        logic          rise, fall, rep_fire;

        assign rise = s2 && !stable && (cnt == DB_LAST);
        assign fall = !s2 && stable && (cnt == DB_LAST);

        always_ff @(posedge CP or negedge _CR) begin
            if (!_CR) begin
                s1     <= 1'b0;
                s2     <= 1'b0;
                stable <= 1'b0;
                cnt    <= '0;
                pulse  <= 1'b0;
            end else begin
                s1    <= keys.key_raw[i];
                s2    <= s1;
                pulse <= rise | rep_fire;
                if (s2 == stable) begin
                    cnt <= '0;
                end else if (cnt != DB_LAST) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    stable <= s2;
                    cnt    <= '0;
                end
            end
        end

        if (i == 2 || i == 3) begin : g_repeat
            rep_state_t    state;
            logic [TW-1:0] timer;

            // A release on the same edge as a timer expiry suppresses that repeat.
            assign rep_fire = !fall &&
                              (((state == HELD)   && (timer == RD_LAST)) ||
                               ((state == REPEAT) && (timer == RR_LAST)));

            always_ff @(posedge CP or negedge _CR) begin
                if (!_CR) begin
                    state <= IDLE;
                    timer <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            timer <= '0;
                            if (rise) state <= HELD;
                        end
                        HELD, REPEAT: begin
                            if (fall) begin
                                state <= IDLE;
                                timer <= '0;
                            end else if (rep_fire) begin
                                state <= REPEAT;
                                timer <= '0;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            timer <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_no_repeat
            assign rep_fire = 1'b0;
        end

        assign pulse_v[i] = pulse;
        assign level_v[i] = stable;
    end

    assign keys.key_pulse = pulse_v;
    assign keys.key_level = level_v;

endmodule
